uart_rx: RTL and testbench

- 8-bit asynchronous serial receiver, 8N1 frame format; the receive-side counterpart to the UART transmit path in the BLDC command link.
- Oversamples the `rx_in` pin with a counter on the system clock and validates the start bit at mid-bit.
- Shifts in data LSB-first and checks the stop bit.
- Presents each received byte with a single-cycle valid strobe to the motor command decoder.

---
 rtl/uart_rx.sv | 162 ++++++++++++++++
 tb/tb_uart_rx.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: oversampling 8N1 serial receiver with mid-bit start validation and a one-cycle byte strobe.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module uart_rx #(
   parameter int CLKS_PER_BIT = 32,
   parameter int DATA_BITS    = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx_in,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 busy
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int BIT_W = $clog2(DATA_BITS + 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_IDLE
`ifdef UART_RX_PARITY_EN
      , PARITY
`endif
   } state_t;

   state_t               state;
   logic                 sync1;
   logic                 rx_s;
   logic [CNT_W-1:0]     clk_cnt;
   logic [BIT_W-1:0]     bit_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_bad;

`ifdef UART_RX_PARITY_EN
   logic par_bit;
   assign par_bad = ^{shreg, par_bit};
`else
   assign par_bad    = 1'b0;
   assign parity_err = 1'b0;
`endif

   // NOTE: every register lives in this one clocked block and uses <=, so all
   // reads see the pre-edge value; strobes default low and are set for one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1     <= 1'b1;   // synchronizer resets to the idle line level
         rx_s      <= 1'b1;
         state     <= IDLE;
         clk_cnt   <= '0;
         bit_cnt   <= '0;
         shreg     <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bit    <= 1'b0;
         parity_err <= 1'b0;
`endif
      end else begin
         sync1     <= rx_in;
         rx_s      <= sync1;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err <= 1'b0;
`endif
         case (state)
            IDLE: begin
               clk_cnt <= '0;
               if (!rx_s) begin
                  state <= START;
                  busy  <= 1'b1;
               end
            end
            START: begin
               if (clk_cnt == HALF_LAST) begin
                  clk_cnt <= '0;
                  if (rx_s) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end else begin
                     state <= DATA;
                  end
               end else begin
                  clk_cnt <= clk_cnt + CNT_W'(1);
               end
            end
            DATA: begin
               if (clk_cnt == BIT_LAST) begin
                  clk_cnt <= '0;
                  shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                  if (bit_cnt == DATA_LAST) begin
                     bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                     state   <= PARITY;
`else
                     state   <= STOP;
`endif
                  end else begin
                     bit_cnt <= bit_cnt + BIT_W'(1);
                  end
               end else begin
                  clk_cnt <= clk_cnt + CNT_W'(1);
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (clk_cnt == BIT_LAST) begin
                  clk_cnt <= '0;
                  par_bit <= rx_s;
                  state   <= STOP;
               end else begin
                  clk_cnt <= clk_cnt + CNT_W'(1);
               end
            end
`endif
            STOP: begin
               if (clk_cnt == BIT_LAST) begin
                  clk_cnt <= '0;
                  if (!rx_s) begin
                     frame_err <= 1'b1;   // framing error outranks parity
                     state     <= WAIT_IDLE;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                     if (par_bad) begin
`ifdef UART_RX_PARITY_EN
                        parity_err <= 1'b1;
`endif
                     end else begin
                        rx_data  <= shreg;
                        rx_valid <= 1'b1;
                     end
                  end
               end else begin
                  clk_cnt <= clk_cnt + CNT_W'(1);
               end
            end
            WAIT_IDLE: begin
               if (rx_s) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives directed and random serial frames into uart_rx and compares
// the strobes against a frame-level model of what each frame should produce.
module tb_uart_rx;

   localparam int N  = 32;
   localparam int DW = 8;
`ifdef UART_RX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int LAT = 2 + N / 2 + N * (DW + 1 + PAR);

   logic          clk = 1'b0;
   logic          rst;
   logic          rx_in;
   logic [DW-1:0] rx_data;
   logic          rx_valid;
   logic          frame_err;
   logic          parity_err;
   logic          busy;

   uart_rx #(.CLKS_PER_BIT(N), .DATA_BITS(DW)) dut (
      .clk        (clk),
      .rst        (rst),
      .rx_in      (rx_in),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .frame_err  (frame_err),
      .parity_err (parity_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Observed behaviour, gathered on the falling edge.
   int            cyc = 0;
   logic [DW-1:0] got_q[$];
   int            got_t[$];
   int            ferr_n = 0, perr_n = 0, overlap_n = 0, busy_after_bad = 0;
   bit            busy_seen = 0, prev_valid = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rx_valid) begin
         got_q.push_back(rx_data);
         got_t.push_back(cyc);
      end
      if (frame_err) ferr_n++;
      if (parity_err) perr_n++;
      if (int'(rx_valid) + int'(frame_err) + int'(parity_err) > 1) overlap_n++;
      if (busy) busy_seen = 1;
      if (prev_valid && busy) busy_after_bad++;
      prev_valid = rx_valid;
   end

   // Frame-level reference: what each transmitted frame must produce.
   logic [DW-1:0] exp_q[$];
   int            ferr_exp = 0, perr_exp = 0;
   logic [DW-1:0] last_good = '0;

   function automatic void model_frame(input logic [DW-1:0] d, input bit stop_bit, input bit par_flip);
      if (!stop_bit)
         ferr_exp++;
      else if ((PAR != 0) && par_flip)
         perr_exp++;
      else begin
         exp_q.push_back(d);
         last_good = d;
      end
   endfunction

   task automatic drive(input bit b, input int cycles);
      rx_in = b;
      repeat (cycles) @(negedge clk);
   endtask

   task automatic send_frame(input logic [DW-1:0] d, input bit stop_bit, input bit par_flip,
                             output int t0);
      t0 = cyc;
      drive(1'b0, N);
      for (int i = 0; i < DW; i++) drive(d[i], N);
      if (PAR != 0) drive((^d) ^ par_flip, N);
      drive(stop_bit, N);
      model_frame(d, stop_bit, par_flip);
   endtask

   task automatic check_scenario(input string tag);
      check({tag, "_nvalid"}, got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         check($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
      check({tag, "_frame_err"}, ferr_n, ferr_exp);
      check({tag, "_parity_err"}, perr_n, perr_exp);
      check({tag, "_rx_data"}, rx_data, last_good);
      got_q.delete();
      got_t.delete();
      exp_q.delete();
      ferr_n = 0; perr_n = 0; ferr_exp = 0; perr_exp = 0;
   endtask

   initial begin
      int            t0;
      logic [DW-1:0] v;
      rst   = 1'b1;
      rx_in = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_rx_data", rx_data, 0);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_frame_err", frame_err, 0);
      check("rst_parity_err", parity_err, 0);
      check("rst_busy", busy, 0);
      rst = 1'b0;
      drive(1'b1, 8);

      // Single ideal frame with latency measured from the first sampling edge.
      send_frame(8'hA5, 1'b1, 1'b0, t0);
      drive(1'b1, 4);
      check("a5_latency", (got_t.size() > 0) ? got_t[0] - t0 : -1, 1 + LAT);
      check_scenario("a5");

      // Short low pulse is rejected at the mid-start check.
      busy_seen = 0;
      drive(1'b0, 8);
      drive(1'b1, N);
      check("glitch_busy_seen", busy_seen, 1);
      check("glitch_busy_now", busy, 0);
      send_frame(8'h3C, 1'b1, 1'b0, t0);
      drive(1'b1, 4);
      check_scenario("glitch");

      // Break condition: stop low, line held low.
      send_frame(8'h55, 1'b0, 1'b0, t0);
      drive(1'b0, 100);
      check("break_busy", busy, 1);
      check("break_nvalid", got_q.size(), 0);
      drive(1'b1, N);
      send_frame(8'h81, 1'b1, 1'b0, t0);
      drive(1'b1, 4);
      check_scenario("break");

      // Back-to-back frames with no idle gap.
      send_frame(8'h00, 1'b1, 1'b0, t0);
      send_frame(8'hFF, 1'b1, 1'b0, t0);
      send_frame(8'h7E, 1'b1, 1'b0, t0);
      drive(1'b1, 4);
      check_scenario("b2b");

      // Reset in the middle of the data bits.
      v = 8'hC3;
      drive(1'b0, N);
      for (int i = 0; i < 4; i++) drive(v[i], N);
      rst   = 1'b1;
      rx_in = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      last_good = '0;
      check("midrst_rx_data", rx_data, 0);
      check("midrst_busy", busy, 0);
      drive(1'b1, 2 * N);
      send_frame(8'h12, 1'b1, 1'b0, t0);
      drive(1'b1, 4);
      check_scenario("midrst");

      if (PAR != 0) begin
         send_frame(8'h07, 1'b1, 1'b0, t0);
         drive(1'b1, 4);
         check_scenario("par_ok");
         send_frame(8'h07, 1'b1, 1'b1, t0);
         drive(1'b1, 4);
         check_scenario("par_bad");
      end

      // Random frames, gaps from none to a full bit, occasional bad stop/parity.
      for (int k = 0; k < 24; k++) begin
         logic [DW-1:0] d;
         bit            stop_bit, par_flip;
         int            gap;
         d        = DW'($urandom);
         stop_bit = ($urandom_range(0, 5) != 0);
         par_flip = (PAR != 0) && ($urandom_range(0, 4) == 0);
         gap      = stop_bit ? int'($urandom_range(0, N)) : N + int'($urandom_range(0, N));
         send_frame(d, stop_bit, par_flip, t0);
         if (gap > 0) drive(1'b1, gap);
      end
      drive(1'b1, 4);
      check_scenario("random");

      check("strobe_overlap", overlap_n, 0);
      check("busy_after_strobe", busy_after_bad, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
